mult_iter: RTL and testbench

Parametrised iterative multiplier for the execute stage. It replaces the single-cycle behavioural multiply with an R-bits-per-cycle shift-add engine. It has a start/busy/done handshake, true signed and unsigned modes, and a cancel input for pipeline flushes. The 2W-bit product feeds the HI/LO registers. The hazard unit stalls dependent instructions while `busy` is high.

---
 rtl/mult_iter_pkg.sv | 21 ++
 rtl/mult_iter_if.sv | 24 ++
 rtl/mult_iter_step.sv | 31 +++
 rtl/mult_iter.sv | 93 +++++++++
 tb/tb_mult_iter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_iter_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
// Pure declarations: no latency or flow-control behaviour of its own.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    // Cycles from the start-sampling edge to the cycle in which done is high.
    function automatic int MULT_LAT(input int w, input int r);
        return w / r + 2;
    endfunction

    function automatic bit r_allowed(input int r);
        return (r == 1) || (r == 2) || (r == 4);
    endfunction

endpackage

// File: rtl/mult_iter_if.sv
// Request/result bundle between the execute stage and the multiplier.
// Start is only honoured while busy is low; done is a one-cycle strobe.
interface mult_iter_if #(
    parameter int W = 32
);
    logic           start;
    logic           Is_signed;
    logic           cancel;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] s;

    modport master (
        output start, Is_signed, cancel, a, b,
        input  busy, done, s
    );

    modport slave (
        input  start, Is_signed, cancel, a, b,
        output busy, done, s
    );
endinterface

// File: rtl/mult_iter_step.sv
// Combinational R-bit partial product, shifted into place and added to the accumulator.
// Zero latency; no flow control, the caller decides when to register the sum.
module mult_step #(
    parameter int W  = 32,
    parameter int R  = 1,
    parameter int CW = 5
) (
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   mcand,
    input  logic [R-1:0]   mplier_lo,
    input  logic [CW-1:0]  cnt,
    output logic [2*W-1:0] acc_nxt
);
    localparam int SW = $clog2(2 * W);

    logic [SW-1:0]  shamt;
    logic [2*W-1:0] pp;

    assign shamt = SW'(cnt) * SW'(R);

    always_comb begin
        pp = '0;
        for (int j = 0; j < R; j++) begin
            if (mplier_lo[j]) begin
                pp = pp + ({{W{1'b0}}, mcand} << j);
            end
        end
        acc_nxt = acc + (pp << shamt);
    end

endmodule

// File: rtl/mult_iter.sv
// Iterative signed/unsigned multiplier retiring R multiplier bits per cycle.
// Latency W/R+2 from accepted start to done; start is ignored while busy, cancel flushes to idle.
module mult_iter
    import mult_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    mult_iter_if.slave bus
);
    localparam int             CW   = $clog2(W / R);
    localparam logic [CW-1:0]  LAST = CW'(W / R - 1);

    if (!r_allowed(R) || (W % R) != 0 || (W % 2) != 0 || W < 8) begin : g_bad_param
        $error("mult_iter: unsupported W/R combination");
    end

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           neg;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [2*W-1:0] s_q;

    // Two's-complement magnitude; -2^(W-1) maps onto itself, which is correct as unsigned.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sg);
        return (sg && x[W-1]) ? (~x + 1'b1) : x;
    endfunction

    mult_step #(
        .W  (W),
        .R  (R),
        .CW (CW)
    ) u_step (
        .acc       (acc),
        .mcand     (mcand),
        .mplier_lo (mplier[R-1:0]),
        .cnt       (cnt),
        .acc_nxt   (acc_nxt)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            s_q    <= '0;
        end else if (bus.cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        mcand  <= mag(bus.a, bus.Is_signed);
                        mplier <= mag(bus.b, bus.Is_signed);
                        neg    <= bus.Is_signed & (bus.a[W-1] ^ bus.b[W-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> R;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    acc   <= neg ? (~acc + 1'b1) : acc;
                    s_q   <= neg ? (~acc + 1'b1) : acc;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN) || (state == SIGN);
    assign bus.done = (state == DONE);
    assign bus.s    = s_q;

endmodule

// File: tb/tb_mult_iter.sv
// Scoreboarded bench: W=32/R=1 directed and random traffic, plus random sweeps of other W/R.
module tb_mult_iter;
    import mult_pkg::*;

    typedef struct {
        logic [63:0] s;
        int unsigned due;
    } exp_t;

    localparam int L0 = MULT_LAT(32, 1);

    logic        clk = 1'b0;
    logic        rst0;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        q0[$];
    exp_t        m0;
    logic [63:0] last_s = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    // Reference product from plain integer arithmetic on the operand values.
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic sg);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        p;
        logic [63:0]        mask;
        sa = $signed({32'd0, a});
        sb = $signed({32'd0, b});
        if (sg && a[w-1]) sa = sa - (64'sd1 <<< w);
        if (sg && b[w-1]) sb = sb - (64'sd1 <<< w);
        p    = sa * sb;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return p & mask;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0:       r = 32'd0;
            1:       r = 32'd1 << (w - 1);
            2:       r = 32'hFFFF_FFFF;
            default: r = $urandom;
        endcase
        return r & (32'hFFFF_FFFF >> (32 - w));
    endfunction

    mult_iter_if #(.W(32)) if0 ();
    mult_iter #(.W(32), .R(1)) u0 (.Clk(clk), .Reset(rst0), .bus(if0));

    always @(negedge clk) begin
        if (!rst0 && if0.done) begin
            chk("u0_busy_in_done", if0.busy, 1'b0);
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL u0_spurious_done: done at cycle %0d, none expected", cyc);
            end else begin
                m0 = q0.pop_front();
                chk("u0_product", if0.s, m0.s);
                chk("u0_latency", cyc, m0.due);
                last_s = m0.s;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg);
        exp_t e;
        if0.a         = a;
        if0.b         = b;
        if0.Is_signed = sg;
        if0.start     = 1'b1;
        e.s   = ref_prod(32, a, b, sg);
        e.due = cyc + L0;
        q0.push_back(e);
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (if0.busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_timeout("u0_wait_idle");
    endtask

    task automatic wait_done();
        int t = 0;
        while (!if0.done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_timeout("u0_wait_done");
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int GW = (gi == 2) ? 16 : 32;
        localparam int GR = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);
        localparam int GL = MULT_LAT(GW, GR);

        logic rst_g;
        logic fin;
        exp_t q[$];
        exp_t m;

        mult_iter_if #(.W(GW)) bus ();
        mult_iter #(.W(GW), .R(GR)) dut (.Clk(clk), .Reset(rst_g), .bus(bus));

        always @(negedge clk) begin
            if (!rst_g && bus.done) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL w%0dr%0d_spurious_done: done at cycle %0d", GW, GR, cyc);
                end else begin
                    m = q.pop_front();
                    chk($sformatf("w%0dr%0d_product", GW, GR), bus.s, m.s);
                    chk($sformatf("w%0dr%0d_latency", GW, GR), cyc, m.due);
                end
            end
        end

        initial begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        sg;
            exp_t        e;
            int          t;
            fin           = 1'b0;
            rst_g         = 1'b1;
            bus.start     = 1'b0;
            bus.cancel    = 1'b0;
            bus.Is_signed = 1'b0;
            bus.a         = '0;
            bus.b         = '0;
            repeat (3) @(negedge clk);
            rst_g = 1'b0;
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                t = 0;
                while (bus.busy && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 100) fail_timeout($sformatf("w%0dr%0d_wait_idle", GW, GR));
                ra = pick(GW);
                rb = pick(GW);
                sg = 1'($urandom_range(0, 1));
                bus.a         = ra[GW-1:0];
                bus.b         = rb[GW-1:0];
                bus.Is_signed = sg;
                bus.start     = 1'b1;
                e.s   = ref_prod(GW, ra, rb, sg);
                e.due = cyc + GL;
                q.push_back(e);
                @(negedge clk);
                bus.start = 1'b0;
            end
            t = 0;
            while (q.size() != 0 && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("w%0dr%0d_drain", GW, GR), q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int bc;
        int t;
        logic [31:0] ra;
        logic [31:0] rb;
        rst0          = 1'b1;
        if0.start     = 1'b0;
        if0.cancel    = 1'b0;
        if0.Is_signed = 1'b0;
        if0.a         = '0;
        if0.b         = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", if0.busy, 1'b0);
        chk("rst_done", if0.done, 1'b0);
        chk("rst_s", if0.s, 64'd0);
        rst0 = 1'b0;
        @(negedge clk);

        issue(32'd7, 32'd6, 1'b0);
        bc = 0;
        while (if0.busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        chk("busy_cycles", bc, 33);

        wait_idle(); issue(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_idle(); issue(32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_idle(); issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle(); issue(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_idle(); issue(32'd0, 32'hFFFF_FFFF, 1'b1);

        // Start held high with fresh operands while busy must be ignored.
        wait_idle(); issue(32'd1234, 32'd5678, 1'b0);
        if0.start = 1'b1;
        if0.a     = 32'hDEAD_BEEF;
        if0.b     = 32'h1234_5678;
        repeat (20) @(negedge clk);
        if0.start = 1'b0;

        wait_done(); issue(32'h0001_0001, 32'hFFFF_0000, 1'b1);
        wait_done(); issue(32'h7FFF_FFFF, 32'h8000_0001, 1'b1);

        wait_idle(); issue(32'd99, 32'd101, 1'b1);
        repeat (9) @(negedge clk);
        if0.cancel = 1'b1;
        void'(q0.pop_back());
        @(negedge clk);
        if0.cancel = 1'b0;
        chk("cancel_busy", if0.busy, 1'b0);
        chk("cancel_done", if0.done, 1'b0);
        chk("cancel_s_kept", if0.s, last_s);
        repeat (40) @(negedge clk);

        if0.a      = 32'd3;
        if0.b      = 32'd4;
        if0.start  = 1'b1;
        if0.cancel = 1'b1;
        @(negedge clk);
        if0.start  = 1'b0;
        if0.cancel = 1'b0;
        chk("cancel_start_busy", if0.busy, 1'b0);
        repeat (40) @(negedge clk);

        wait_idle(); issue(32'd55, 32'd66, 1'b0);
        repeat (5) @(negedge clk);
        rst0 = 1'b1;
        q0.delete();
        @(negedge clk);
        chk("midrst_s", if0.s, 64'd0);
        chk("midrst_busy", if0.busy, 1'b0);
        chk("midrst_done", if0.done, 1'b0);
        rst0   = 1'b0;
        last_s = '0;
        @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            wait_idle();
            ra = pick(32);
            rb = pick(32);
            issue(ra, rb, 1'($urandom_range(0, 1)));
        end
        t = 0;
        while (q0.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("u0_drain", q0.size(), 0);

        t = 0;
        while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_timeout("sweep_finish");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
